// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and timing constants for the sprite fetch path.
// Imported by the fetch pipeline and its address generator.
package sprite_pkg;

  typedef logic [3:0] pix_idx_t;

  localparam int H_ACTIVE      = 1280;
  localparam int V_ACTIVE      = 720;
  localparam int HCOUNT_W      = 11;
  localparam int VCOUNT_W      = 10;
  localparam int FETCH_LATENCY = 3;

endpackage

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: stage-0 hit test, horizontal flip and sprite address.
// Purely combinational; the caller registers the results.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter  int SPRITE_W = 64,
  parameter  int SPRITE_H = 32,
  localparam int AW       = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic [HCOUNT_W-1:0] hcount_i,
  input  logic [VCOUNT_W-1:0] vcount_i,
  input  logic                valid_i,
  input  logic [11:0]         x_i,
  input  logic [10:0]         y_i,
  input  logic                flip_i,
  output logic                in_box_o,
  output logic [AW-1:0]       addr_o
);

  localparam int CW = $clog2(SPRITE_W);

  logic [12:0]   dx;
  logic [12:0]   dy;
  logic [CW-1:0] col;
  logic          in_x;
  logic          in_y;

  // Offsets into the sprite; negative offsets have bit 12 set.
  // Width is a power of two, so W-1-dx is just dx with bits inverted.
  always_comb begin
    dx       = {2'b00, hcount_i} - {x_i[11], x_i};
    dy       = {3'b000, vcount_i} - {{2{y_i[10]}}, y_i};
    in_x     = !dx[12] && (dx < 13'(SPRITE_W));
    in_y     = !dy[12] && (dy < 13'(SPRITE_H));
    in_box_o = valid_i && in_x && in_y;
    col      = dx[CW-1:0] ^ {CW{flip_i}};
    addr_o   = '0;
    if (in_box_o) addr_o = AW'({dy, col});
  end

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// xilinx_single_port_ram_read_first: single-port block RAM, read-first,
// optional output register (HIGH_PERFORMANCE gives 2-cycle read latency).
module xilinx_single_port_ram_read_first #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string INIT_FILE       = ""
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] bram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  // Array contents come from INIT_FILE through the implementation flow.
  if (INIT_FILE == "") begin : g_blank_init
  end else begin : g_file_init
  end

  // Read-first port: old word is returned when writing.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) bram[addra] <= dina;
      ram_data <= bram[addra];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
    assign douta = ram_data;
  end else begin : g_out_reg
    logic [RAM_WIDTH-1:0] douta_q;
    // Output register, cleared by rsta.
    always_ff @(posedge clka) begin
      if (rsta) douta_q <= '0;
      else if (regcea) douta_q <= ram_data;
    end
    assign douta = douta_q;
  end

endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: per-pixel 4bpp sprite index fetch from block RAM,
// with coordinates and valid delayed to match the 3-cycle fetch.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int    SPRITE_W  = 64,
  parameter int    SPRITE_H  = 32,
  parameter string INIT_FILE = "sprite.mem"
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                valid_in,
  input  logic                new_frame_in,
  input  logic [11:0]         x_in,
  input  logic [10:0]         y_in,
  input  logic                flip_h_in,
  output pix_idx_t            idx_out,
  output logic                hit_out,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                valid_out
);

  localparam int AW = $clog2(SPRITE_W * SPRITE_H);
  localparam int L  = FETCH_LATENCY;

  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        flip_q, flip_d;

  logic          in_box;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_q;
  pix_idx_t      ram_dout;

  logic [L-1:0]          in_box_q;
  logic [L-1:0]          valid_q;
  logic [HCOUNT_W-1:0]   hc_q [L];
  logic [VCOUNT_W-1:0]   vc_q [L];

  // Position is captured only on the frame pulse, so no mid-frame tearing.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    flip_d = flip_q;
    if (new_frame_in) begin
      x_d    = x_in;
      y_d    = y_in;
      flip_d = flip_h_in;
    end
  end

  // Latched position register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q    <= '0;
      y_q    <= '0;
      flip_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      flip_q <= flip_d;
    end
  end

  sprite_addr_gen #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H)
  ) u_addr_gen (
    .hcount_i(hcount_in),
    .vcount_i(vcount_in),
    .valid_i (valid_in),
    .x_i     (x_q),
    .y_i     (y_q),
    .flip_i  (flip_q),
    .in_box_o(in_box),
    .addr_o  (addr)
  );

  // Stage 0 address plus sideband shift registers tracking the RAM.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q   <= '0;
      in_box_q <= '0;
      valid_q  <= '0;
      for (int i = 0; i < L; i++) begin
        hc_q[i] <= '0;
        vc_q[i] <= '0;
      end
    end else begin
      addr_q   <= addr;
      in_box_q <= {in_box_q[L-2:0], in_box};
      valid_q  <= {valid_q[L-2:0], valid_in};
      hc_q[0]  <= hcount_in;
      vc_q[0]  <= vcount_in;
      for (int i = 1; i < L; i++) begin
        hc_q[i] <= hc_q[i-1];
        vc_q[i] <= vc_q[i-1];
      end
    end
  end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH      (4),
    .RAM_DEPTH      (SPRITE_W * SPRITE_H),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
    .INIT_FILE      (INIT_FILE)
  ) u_ram (
    .addra (addr_q),
    .dina  (4'h0),
    .clka  (clk_in),
    .wea   (1'b0),
    .ena   (1'b1),
    .rsta  (rst_in),
    .regcea(1'b1),
    .douta (ram_dout)
  );

  assign idx_out    = in_box_q[L-1] ? ram_dout : '0;
  assign hit_out    = in_box_q[L-1] && (ram_dout != '0);
  assign hcount_out = hc_q[L-1];
  assign vcount_out = vc_q[L-1];
  assign valid_out  = valid_q[L-1];

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: directed and random pixels against a coordinate model.
// Sprite RAM is preloaded so that address k holds k[3:0].
module tb_sprite_fetch;
  import sprite_pkg::*;

  localparam int SW = 64;
  localparam int SH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        vld;
  logic        nf;
  logic [11:0] xi;
  logic [10:0] yi;
  logic        fl;

  pix_idx_t    idx_o;
  logic        hit_o;
  logic [10:0] hc_o;
  logic [9:0]  vc_o;
  logic        vld_o;

  always #5 clk = ~clk;

  sprite_fetch #(
    .SPRITE_W (SW),
    .SPRITE_H (SH),
    .INIT_FILE("")
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .hcount_in   (hc),
    .vcount_in   (vc),
    .valid_in    (vld),
    .new_frame_in(nf),
    .x_in        (xi),
    .y_in        (yi),
    .flip_h_in   (fl),
    .idx_out     (idx_o),
    .hit_out     (hit_o),
    .hcount_out  (hc_o),
    .vcount_out  (vc_o),
    .valid_out   (vld_o)
  );

  typedef struct {
    int h;
    int v;
    bit val;
    int idx;
    bit hit;
    bit kchk;
    int kidx;
    bit khit;
  } exp_t;

  exp_t q[$];
  int   mem [SW*SH];
  int   lx, ly;
  bit   lf;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(string tag, int got, int exp, int h, int v);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s pix(%0d,%0d) observed %0h expected %0h",
             tag, h, v, got, exp);
    end
  endtask

  // Expected output for one input pixel, from the latched position.
  function automatic exp_t model(int h, int v, bit val);
    exp_t e;
    int   dx, dy, col;
    e     = '{default: 0};
    e.h   = h;
    e.v   = v;
    e.val = val;
    dx    = h - lx;
    dy    = v - ly;
    if (val && dx >= 0 && dx < SW && dy >= 0 && dy < SH) begin
      col   = lf ? (SW - 1 - dx) : dx;
      e.idx = mem[dy * SW + col];
      e.hit = (e.idx != 0);
    end
    return e;
  endfunction

  task automatic step(bit r, int h, int v, bit val, bit nfv,
                      bit kc = 0, int ki = 0, bit kh = 0);
    exp_t e;
    @(negedge clk);
    rst = r;
    hc  = 11'(h);
    vc  = 10'(v);
    vld = val;
    nf  = nfv;
    if (r) begin
      q.delete();
      repeat (3) q.push_back('{default: 0});
      lx = 0;
      ly = 0;
      lf = 0;
    end else begin
      e      = model(h, v, val);
      e.kchk = kc;
      e.kidx = ki;
      e.khit = kh;
      q.push_back(e);
      if (nfv) begin
        lx = int'($signed(xi));
        ly = int'($signed(yi));
        lf = fl;
      end
    end
    @(posedge clk);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("idx",    int'(idx_o), e.idx,       e.h, e.v);
      chk("hit",    int'(hit_o), int'(e.hit), e.h, e.v);
      chk("hcount", int'(hc_o),  e.h,         e.h, e.v);
      chk("vcount", int'(vc_o),  e.v,         e.h, e.v);
      chk("valid",  int'(vld_o), int'(e.val), e.h, e.v);
      if (e.kchk) begin
        chk("k_idx", int'(idx_o), e.kidx,       e.h, e.v);
        chk("k_hit", int'(hit_o), int'(e.khit), e.h, e.v);
      end
    end
  endtask

  task automatic probe(int h, int v, int ki, bit kh);
    step(0, h, v, 1, 0, 1, ki, kh);
  endtask

  task automatic latch(int x, int y, bit f);
    xi = 12'(x);
    yi = 11'(y);
    fl = f;
    step(0, 0, 0, 0, 1);
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int h, v;
    for (int k = 0; k < SW*SH; k++) begin
      mem[k] = k % 16;
      dut.u_ram.bram[k] <= 4'(k);
    end
    rst = 1; hc = '0; vc = '0; vld = 0; nf = 0;
    xi = '0; yi = '0; fl = 0;
    lx = 0; ly = 0; lf = 0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    latch(100, 50, 0);
    probe(100, 50, 0, 0);
    probe(101, 50, 1, 1);
    probe(163, 51, 15, 1);
    probe(99, 50, 0, 0);
    probe(164, 50, 0, 0);
    probe(100, 49, 0, 0);
    probe(100, 82, 0, 0);
    probe(100, 81, 0, 0);
    flush();

    latch(100, 50, 1);
    probe(100, 50, 15, 1);
    probe(163, 50, 0, 0);
    probe(101, 50, 14, 1);
    flush();

    latch(-10, 0, 0);
    probe(0, 0, 10, 1);
    probe(53, 0, 15, 1);
    probe(54, 0, 0, 0);
    flush();

    latch(100, 50, 0);
    xi = 12'(500);
    probe(101, 50, 1, 1);
    probe(500, 50, 0, 0);
    step(0, 0, 0, 0, 1);
    probe(500, 50, 0, 0);
    probe(501, 50, 1, 1);
    flush();

    // Frame pulse coinciding with a pixel: pixel sees the old position.
    xi = 12'(200);
    step(0, 501, 50, 1, 1, 1, 1, 1);
    probe(201, 50, 1, 1);
    flush();

    // Random positions, mid-frame input churn and frame pulses.
    for (int n = 0; n < 600; n++) begin
      xi = 12'(int'($urandom_range(0, 1400)) - 80);
      yi = 11'(int'($urandom_range(0, 800)) - 40);
      fl = 1'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        step(0, 0, 0, 0, 1);
      end else begin
        h = lx + int'($urandom_range(0, 80)) - 8;
        v = ly + int'($urandom_range(0, 40)) - 4;
        if (h < 0) h = 0;
        if (h > H_ACTIVE - 1) h = H_ACTIVE - 1;
        if (v < 0) v = 0;
        if (v > V_ACTIVE - 1) v = V_ACTIVE - 1;
        step(0, h, v, ($urandom_range(0, 4) != 0), 0);
      end
    end
    flush();

    // Full line with a one-cycle reset in the middle.
    latch(580, 190, 0);
    for (int p = 0; p < H_ACTIVE; p++)
      step((p == 600), p, 200, 1, 0);
    flush();

    latch(20, 180, 0);
    for (int p = 0; p < 120; p++)
      step(0, p, 200, 1, 0);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
